reg_bank_arbiter: RTL



---
 rtl/reg_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/reg_bank_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and default sizes for the register-bank write arbiter.
// No logic; imported by reg_bank_arbiter and its testbench.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first set bit of elig at or after ptr, wrapping to 0.
// Combinational, zero latency; no backpressure of its own.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [PTR_W-1:0]   win_idx,
    output logic               win_vld
);

    always_comb begin
        int cand;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        cand    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (!win_vld && elig[cand]) begin
                win_vld      = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter committing one granted write per cycle into a shared register bank.
// Latency: req -> gnt 1 cycle, gnt -> bank_q 1 cycle; requesters hold req until granted.
// REG_ARB_LOCK_EN adds burst hold (LOCK state) driven by the lock input.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    input  logic [NUM_REQ-1:0]        lock,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DEPTH*DATA_W-1:0]   bank_q,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_d, elig, pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld, busy_d;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_sel_addr;
    logic [DATA_W-1:0]  wr_sel_data;

    // Masking the current holder keeps a lone requester from winning back-to-back.
    assign elig = req & ~gnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .elig    (elig),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

`ifdef REG_ARB_LOCK_EN
    logic hold;
    assign hold = |(gnt & lock & req);
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            busy    <= busy_d;
            ptr_q   <= ptr_d;
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_en && wr_sel_addr == ADDR_W'(k)) begin
                    bank_q[k*DATA_W +: DATA_W] <= wr_sel_data;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = pick_vld ? GRANT : IDLE;
`ifdef REG_ARB_LOCK_EN
            GRANT, LOCK: state_d = hold ? LOCK : (pick_vld ? GRANT : IDLE);
`else
            GRANT: state_d = pick_vld ? GRANT : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Grant and pointer follow the state being entered, so both land registered together.
    always_comb begin
        gnt_d  = '0;
        ptr_d  = ptr_q;
        busy_d = 1'b0;
        case (state_d)
            GRANT: begin
                gnt_d  = pick_oh;
                ptr_d  = (pick_idx == PTR_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                busy_d = 1'b1;
            end
`ifdef REG_ARB_LOCK_EN
            LOCK: begin
                gnt_d  = gnt;
                busy_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_sel_addr = '0;
        wr_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                wr_en       = 1'b1;
                wr_sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
                wr_sel_data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
